// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the ICache
// refill path and the DCache refill/writeback path, one transaction at a time.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH = 128,
    parameter int ADDR_WIDTH = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icacheReadEnable,
    input  logic [ADDR_WIDTH-1:0] icacheAddr,
    output logic                  icacheReadDone,
    output logic [LINE_WIDTH-1:0] icacheReadValue,
    input  logic                  dcacheReadEnable,
    input  logic                  dcacheWriteEnable,
    input  logic [ADDR_WIDTH-1:0] dcacheAddr,
    input  logic [LINE_WIDTH-1:0] dcacheWriteValue,
    output logic                  dcacheReadDone,
    output logic                  dcacheWriteDone,
    output logic [LINE_WIDTH-1:0] dcacheReadValue,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memReadEnable,
    output logic                  memWriteEnable,
    output logic [LINE_WIDTH-1:0] memWriteValue,
    input  logic                  memReadDone,
    input  logic [LINE_WIDTH-1:0] memReadValue,
    input  logic                  memWriteDone
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ICACHE_READ  = 2'd1,
        DCACHE_READ  = 2'd2,
        DCACHE_WRITE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 1'b1 = DCache granted last
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  i_req_s;
    logic                  d_req_s;
    logic                  grant_i_s;

    assign i_req_s   = icacheReadEnable;
    assign d_req_s   = dcacheReadEnable | dcacheWriteEnable;
    // ICache wins when alone, or when both request and DCache had the last turn.
    assign grant_i_s = i_req_s & (~d_req_s | last_grant_q);

    // Next-state, grant bookkeeping and address/data latching.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i_s) begin
                    state_d      = ICACHE_READ;
                    last_grant_d = 1'b0;
                    addr_d       = icacheAddr;
                end else if (d_req_s) begin
                    last_grant_d = 1'b1;
                    addr_d       = dcacheAddr;
                    if (dcacheWriteEnable) begin
                        state_d = DCACHE_WRITE;
                        wdata_d = dcacheWriteValue;
                    end else begin
                        state_d = DCACHE_READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ICACHE_READ, DCACHE_READ: begin
                if (memReadDone) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            DCACHE_WRITE: begin
                if (memWriteDone) begin
                    state_d = IDLE;
                end else begin
                    state_d = DCACHE_WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer and transaction latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign memAddr        = addr_q;
    assign memWriteValue  = wdata_q;
    assign memReadEnable  = (state_q == ICACHE_READ) || (state_q == DCACHE_READ);
    assign memWriteEnable = (state_q == DCACHE_WRITE);

    // Completions pass straight through; a done of the wrong kind is masked by state.
    assign icacheReadDone  = (state_q == ICACHE_READ) & memReadDone;
    assign dcacheReadDone  = (state_q == DCACHE_READ) & memReadDone;
    assign dcacheWriteDone = (state_q == DCACHE_WRITE) & memWriteDone;
    assign icacheReadValue = {LINE_WIDTH{icacheReadDone}} & memReadValue;
    assign dcacheReadValue = {LINE_WIDTH{dcacheReadDone}} & memReadValue;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level arbitration model.
module tb_cache_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          icacheReadEnable;
    logic [33:0]   icacheAddr;
    logic          icacheReadDone;
    logic [127:0]  icacheReadValue;
    logic          dcacheReadEnable;
    logic          dcacheWriteEnable;
    logic [33:0]   dcacheAddr;
    logic [127:0]  dcacheWriteValue;
    logic          dcacheReadDone;
    logic          dcacheWriteDone;
    logic [127:0]  dcacheReadValue;
    logic [33:0]   memAddr;
    logic          memReadEnable;
    logic          memWriteEnable;
    logic [127:0]  memWriteValue;
    logic          memReadDone;
    logic [127:0]  memReadValue;
    logic          memWriteDone;

    int n_tests = 0;
    int n_fail  = 0;

    cache_mem_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(34)) dut (
        .clk(clk), .rst(rst),
        .icacheReadEnable(icacheReadEnable), .icacheAddr(icacheAddr),
        .icacheReadDone(icacheReadDone), .icacheReadValue(icacheReadValue),
        .dcacheReadEnable(dcacheReadEnable), .dcacheWriteEnable(dcacheWriteEnable),
        .dcacheAddr(dcacheAddr), .dcacheWriteValue(dcacheWriteValue),
        .dcacheReadDone(dcacheReadDone), .dcacheWriteDone(dcacheWriteDone),
        .dcacheReadValue(dcacheReadValue),
        .memAddr(memAddr), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
        .memWriteValue(memWriteValue), .memReadDone(memReadDone),
        .memReadValue(memReadValue), .memWriteDone(memWriteDone)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icacheReadEnable  = 1'b0;
        icacheAddr        = 34'h0;
        dcacheReadEnable  = 1'b0;
        dcacheWriteEnable = 1'b0;
        dcacheAddr        = 34'h0;
        dcacheWriteValue  = 128'h0;
        memReadDone       = 1'b0;
        memReadValue      = 128'h0;
        memWriteDone      = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        icacheReadEnable = 1'b1;
        dcacheWriteEnable = 1'b1;
        dcacheAddr = 34'h3_0000_0040;
        step();
        step();
        n_tests++;
        if ({memReadEnable, memWriteEnable} !== 2'b00 || memAddr !== 34'h0 || memWriteValue !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_hold: en=%b addr=%0h wdata=%0h, required en=00 addr=0 wdata=0",
                     {memReadEnable, memWriteEnable}, memAddr, memWriteValue);
        end
        clear_inputs();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if ({memReadEnable, memWriteEnable, icacheReadDone, dcacheReadDone, dcacheWriteDone} !== 5'b0
                || memAddr !== 34'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: en/done=%b addr=%0h, required all 0", i,
                         {memReadEnable, memWriteEnable, icacheReadDone, dcacheReadDone, dcacheWriteDone}, memAddr);
            end
        end
    endtask

    task automatic test_icache_fill();
        apply_reset();
        icacheReadEnable = 1'b1;
        icacheAddr = 34'h0_0000_1000;
        step();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (memReadEnable !== 1'b1 || memWriteEnable !== 1'b0 || memAddr !== 34'h1000 || icacheReadDone !== 1'b0) begin
                n_fail++;
                $display("FAIL ifill_busy[%0d]: rd=%b wr=%b addr=%0h done=%b, required 1 0 1000 0",
                         i, memReadEnable, memWriteEnable, memAddr, icacheReadDone);
            end
            if (i < 2) step();
        end
        memReadDone = 1'b1;
        memReadValue = 128'h0123456789ABCDEF0123456789ABCDEF;
        #1;
        n_tests++;
        if (icacheReadDone !== 1'b1 || icacheReadValue !== 128'h0123456789ABCDEF0123456789ABCDEF || dcacheReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL ifill_done: idone=%b val=%0h ddone=%b, required 1 0123456789abcdef0123456789abcdef 0",
                     icacheReadDone, icacheReadValue, dcacheReadDone);
        end
        step();
        icacheReadEnable = 1'b0;
        memReadDone = 1'b0;
        #1;
        n_tests++;
        if (memReadEnable !== 1'b0 || icacheReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL ifill_after: rd=%b idone=%b, required 0 0", memReadEnable, icacheReadDone);
        end
    endtask

    task automatic test_dcache_write();
        apply_reset();
        dcacheWriteEnable = 1'b1;
        dcacheAddr = 34'h2040;
        dcacheWriteValue = 128'hAAAAAAAAAAAAAAAA5555555555555555;
        step();
        n_tests++;
        if (memWriteEnable !== 1'b1 || memReadEnable !== 1'b0 || memAddr !== 34'h2040
            || memWriteValue !== 128'hAAAAAAAAAAAAAAAA5555555555555555) begin
            n_fail++;
            $display("FAIL dwr_busy: wr=%b rd=%b addr=%0h data=%0h, required 1 0 2040 aaaaaaaaaaaaaaaa5555555555555555",
                     memWriteEnable, memReadEnable, memAddr, memWriteValue);
        end
        memReadDone = 1'b1;
        #1;
        n_tests++;
        if ({icacheReadDone, dcacheReadDone, dcacheWriteDone} !== 3'b000) begin
            n_fail++;
            $display("FAIL dwr_stray_read: dones=%b, required 000", {icacheReadDone, dcacheReadDone, dcacheWriteDone});
        end
        step();
        memReadDone = 1'b0;
        n_tests++;
        if (memWriteEnable !== 1'b1 || memAddr !== 34'h2040) begin
            n_fail++;
            $display("FAIL dwr_still_busy: wr=%b addr=%0h, required 1 2040", memWriteEnable, memAddr);
        end
        memWriteDone = 1'b1;
        #1;
        n_tests++;
        if (dcacheWriteDone !== 1'b1 || dcacheReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL dwr_done: wdone=%b rdone=%b, required 1 0", dcacheWriteDone, dcacheReadDone);
        end
        step();
        dcacheWriteEnable = 1'b0;
        memWriteDone = 1'b0;
        #1;
        n_tests++;
        if (memWriteEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL dwr_after: wr=%b, required 0", memWriteEnable);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int round = 0; round < 3; round++) begin
            icacheReadEnable = 1'b1;
            icacheAddr = 34'h1_0000_0100;
            if (round < 2) begin
                dcacheReadEnable = 1'b1;
                dcacheAddr = 34'h2_0000_0200;
            end
            step();
            // Rounds 0 and 2 expect ICache (last grant DCache), round 1 expects DCache.
            n_tests++;
            if (memReadEnable !== 1'b1 || memAddr !== ((round == 1) ? 34'h2_0000_0200 : 34'h1_0000_0100)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: rd=%b addr=%0h, required rd=1 addr=%0h", round, memReadEnable, memAddr,
                         (round == 1) ? 34'h2_0000_0200 : 34'h1_0000_0100);
            end
            if (round == 1) icacheReadEnable = 1'b0;
            memReadDone = 1'b1;
            #1;
            n_tests++;
            if (icacheReadDone !== (round != 1) || dcacheReadDone !== (round == 1)) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: idone=%b ddone=%b, required %b %b", round,
                         icacheReadDone, dcacheReadDone, round != 1, round == 1);
            end
            step();
            memReadDone = 1'b0;
            if (round == 1) dcacheReadEnable = 1'b0;
            else icacheReadEnable = 1'b0;
            n_tests++;
            if (memReadEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: rd=%b, required 0", round, memReadEnable);
            end
            if (round == 1) step();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        icacheReadEnable = 1'b1;
        icacheAddr = 34'h3_0000_0500;
        step();
        n_tests++;
        if (memReadEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy: rd=%b, required 1", memReadEnable);
        end
        rst = 1'b1;
        icacheReadEnable = 1'b0;
        step();
        rst = 1'b0;
        n_tests++;
        if (memReadEnable !== 1'b0 || memAddr !== 34'h0) begin
            n_fail++;
            $display("FAIL midrst_idle: rd=%b addr=%0h, required 0 0", memReadEnable, memAddr);
        end
        memReadDone = 1'b1;
        #1;
        n_tests++;
        if (icacheReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_late_done: idone=%b, required 0", icacheReadDone);
        end
        step();
        memReadDone = 1'b0;
        n_tests++;
        if (memReadEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stay: rd=%b, required 0", memReadEnable);
        end
    endtask

    task automatic test_dual_enable();
        apply_reset();
        dcacheReadEnable = 1'b1;
        dcacheWriteEnable = 1'b1;
        dcacheAddr = 34'h0_0000_3000;
        dcacheWriteValue = 128'hFEEDFACE_00000000_CAFEBABE_12345678;
        step();
        n_tests++;
        if (memWriteEnable !== 1'b1 || memReadEnable !== 1'b0 || memWriteValue !== 128'hFEEDFACE_00000000_CAFEBABE_12345678) begin
            n_fail++;
            $display("FAIL dual_grant: wr=%b rd=%b data=%0h, required 1 0 feedface00000000cafebabe12345678",
                     memWriteEnable, memReadEnable, memWriteValue);
        end
        memWriteDone = 1'b1;
        #1;
        n_tests++;
        if (dcacheWriteDone !== 1'b1 || dcacheReadDone !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_done: wdone=%b rdone=%b, required 1 0", dcacheWriteDone, dcacheReadDone);
        end
        step();
        clear_inputs();
    endtask

    // Transaction-level model: requesters hold until served, memory answers after
    // a random delay, grants follow alternation whenever both sides are waiting.
    task automatic test_random();
        int           cur;   // 0 none, 1 ICache read, 2 DCache read, 3 DCache write
        int           nxt;
        int           wait_c;
        int           last;  // 0 ICache served last, 1 DCache
        bit           i_cool, d_cool;
        logic [33:0]  g_addr;
        logic [127:0] g_wdata, rdata;
        logic [63:0]  r64;
        apply_reset();
        cur = 0; last = 1; wait_c = 0; i_cool = 1'b0; d_cool = 1'b0;
        g_addr = 34'h0; g_wdata = 128'h0; rdata = 128'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!icacheReadEnable && !i_cool && $urandom_range(0, 3) == 0) begin
                r64 = {$urandom(), $urandom()};
                icacheAddr = r64[33:0];
                icacheReadEnable = 1'b1;
            end
            if (!dcacheReadEnable && !dcacheWriteEnable && !d_cool && $urandom_range(0, 3) == 0) begin
                r64 = {$urandom(), $urandom()};
                dcacheAddr = r64[33:0];
                dcacheWriteValue = {$urandom(), $urandom(), $urandom(), $urandom()};
                if ($urandom_range(0, 1) == 1) dcacheWriteEnable = 1'b1;
                else dcacheReadEnable = 1'b1;
            end
            i_cool = 1'b0;
            d_cool = 1'b0;
            memReadValue = {$urandom(), $urandom(), $urandom(), $urandom()};
            nxt = cur;
            if (cur == 0) begin
                n_tests++;
                if (memReadEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_idle_en[%0d]: rd=%b wr=%b, required 0 0", cyc, memReadEnable, memWriteEnable);
                end
                memReadDone = ($urandom_range(0, 4) == 0);
                memWriteDone = ($urandom_range(0, 4) == 0);
                #1;
                n_tests++;
                if ({icacheReadDone, dcacheReadDone, dcacheWriteDone} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL rnd_idle_done[%0d]: dones=%b, required 000", cyc,
                             {icacheReadDone, dcacheReadDone, dcacheWriteDone});
                end
                if (icacheReadEnable && (!(dcacheReadEnable || dcacheWriteEnable) || last == 1)) begin
                    nxt = 1; last = 0; g_addr = icacheAddr;
                end else if (dcacheReadEnable || dcacheWriteEnable) begin
                    nxt = dcacheWriteEnable ? 3 : 2; last = 1;
                    g_addr = dcacheAddr; g_wdata = dcacheWriteValue;
                end
                wait_c = $urandom_range(0, 3);
            end else begin
                n_tests++;
                if (memReadEnable !== (cur != 3) || memWriteEnable !== (cur == 3) || memAddr !== g_addr
                    || (cur == 3 && memWriteValue !== g_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_busy[%0d]: kind=%0d rd=%b wr=%b addr=%0h wdata=%0h, required addr=%0h wdata=%0h",
                             cyc, cur, memReadEnable, memWriteEnable, memAddr, memWriteValue, g_addr, g_wdata);
                end
                if (wait_c == 0) begin
                    memReadDone = (cur != 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
                    memWriteDone = (cur == 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
                    rdata = memReadValue;
                    #1;
                    n_tests++;
                    if (icacheReadDone !== (cur == 1) || dcacheReadDone !== (cur == 2) || dcacheWriteDone !== (cur == 3)
                        || (cur == 1 && icacheReadValue !== rdata) || (cur == 2 && dcacheReadValue !== rdata)) begin
                        n_fail++;
                        $display("FAIL rnd_done[%0d]: kind=%0d dones=%b ival=%0h dval=%0h, required data %0h", cyc, cur,
                                 {icacheReadDone, dcacheReadDone, dcacheWriteDone}, icacheReadValue, dcacheReadValue, rdata);
                    end
                    nxt = 0;
                end else begin
                    wait_c--;
                    memReadDone = (cur == 3) ? ($urandom_range(0, 1) == 1) : 1'b0;
                    memWriteDone = (cur != 3) ? ($urandom_range(0, 1) == 1) : 1'b0;
                    #1;
                    n_tests++;
                    if ({icacheReadDone, dcacheReadDone, dcacheWriteDone} !== 3'b000) begin
                        n_fail++;
                        $display("FAIL rnd_wait_done[%0d]: kind=%0d dones=%b, required 000", cyc, cur,
                                 {icacheReadDone, dcacheReadDone, dcacheWriteDone});
                    end
                end
            end
            step();
            memReadDone = 1'b0;
            memWriteDone = 1'b0;
            if (cur != 0 && nxt == 0) begin
                if (cur == 1) begin
                    icacheReadEnable = 1'b0; i_cool = 1'b1;
                end else begin
                    dcacheReadEnable = 1'b0; dcacheWriteEnable = 1'b0; d_cool = 1'b1;
                end
            end
            cur = nxt;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_icache_fill();
        test_dcache_write();
        test_simultaneous();
        test_reset_mid();
        test_dual_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
